// File: rtl/lmsm_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : lmsm_sequencer
// Brief    : Expands LM/SM into one data-memory access per set mask bit,
//            stalling upstream until the last access; other ops pass through.
//            Optional macro LMSM_ADDR_CHECK_EN aborts a sequence on address wrap.
// Revision : 1.0 - initial release
// =============================================================================
module lmsm_sequencer #(
  parameter int         AW    = 16,
  parameter int         DW    = 16,
  parameter logic [3:0] LM_OP = 4'd6,
  parameter logic [3:0] SM_OP = 4'd7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [3:0]    opcode_in,
  input  logic [7:0]    reg_mask,
  input  logic [AW-1:0] base_addr,
  input  logic          in_mem_r,
  input  logic          in_mem_w,
  input  logic [DW-1:0] in_store,
  input  logic [2:0]    in_rc_addr,
  input  logic          in_rc_wv,
  input  logic          flush,
  input  logic [DW-1:0] rs_data,
  output logic          stall,
  output logic          busy,
  output logic [2:0]    rs_addr,
  output logic          mem_r,
  output logic          mem_w,
  output logic [AW-1:0] ls_addr,
  output logic [DW-1:0] store_data,
  output logic [3:0]    opcode_out,
  output logic [2:0]    rc_addr,
  output logic          rc_w_valid,
  output logic          valid_out,
  output logic          addr_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mask;
  logic [AW-1:0] r_base;
  logic [3:0]    r_offset;
  logic [3:0]    r_opcode;

  logic          w_is_multi;
  logic          w_start;
  logic          w_last;
  logic          w_wrap;
  logic [2:0]    w_k;
  logic [7:0]    w_rest;
  logic [AW-1:0] w_addr;

  assign w_is_multi = (opcode_in == LM_OP) || (opcode_in == SM_OP);
  assign w_start    = (r_state == ST_IDLE) && in_valid && w_is_multi && (reg_mask != 8'd0);

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    w_k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i]) w_k = 3'(i);
    end
  end

  assign w_rest = r_mask & ~(8'd1 << w_k);
  assign w_last = (w_rest == 8'd0);
  assign w_addr = r_base + AW'(r_offset);

`ifdef LMSM_ADDR_CHECK_EN
  logic r_addr_err;

  // With the check on, the address never passes all-ones, so equality is enough.
  assign w_wrap = !w_last && (w_addr == {AW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else if (!flush && (r_state == ST_XFER) && w_wrap) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err & ~rst;
`else
  assign w_wrap   = 1'b0;
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mask   <= 8'd0;
      r_base   <= '0;
      r_offset <= 4'd0;
      r_opcode <= 4'd0;
    end else if (flush) begin
      r_state  <= ST_IDLE;
      r_mask   <= 8'd0;
      r_offset <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_XFER;
            r_mask   <= reg_mask;
            r_base   <= base_addr;
            r_offset <= 4'd0;
            r_opcode <= opcode_in;
          end
        end
        ST_XFER: begin
          r_mask   <= w_rest;
          r_offset <= r_offset + 4'd1;
          if (w_last || w_wrap) begin
            r_state <= ST_IDLE;
            r_mask  <= 8'd0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall      = 1'b0;
    busy       = 1'b0;
    rs_addr    = 3'd0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    ls_addr    = '0;
    store_data = '0;
    opcode_out = 4'd0;
    rc_addr    = 3'd0;
    rc_w_valid = 1'b0;
    valid_out  = 1'b0;
    if (!rst) begin
      if (r_state == ST_XFER) begin
        busy       = 1'b1;
        valid_out  = 1'b1;
        opcode_out = r_opcode;
        ls_addr    = w_addr;
        stall      = !w_last && !w_wrap;
        if (r_opcode == LM_OP) begin
          mem_r      = 1'b1;
          rc_addr    = w_k;
          rc_w_valid = 1'b1;
        end else begin
          mem_w      = 1'b1;
          rs_addr    = w_k;
          store_data = rs_data;
        end
      end else if (in_valid && !w_is_multi) begin
        valid_out  = 1'b1;
        mem_r      = in_mem_r;
        mem_w      = in_mem_w;
        ls_addr    = base_addr;
        store_data = in_store;
        opcode_out = opcode_in;
        rc_addr    = in_rc_addr;
        rc_w_valid = in_rc_wv;
      end else if (w_start) begin
        stall = 1'b1;
      end
      // Flush kills the access and releases upstream in the same cycle.
      if (flush) begin
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        valid_out  = 1'b0;
        rc_w_valid = 1'b0;
        stall      = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_lmsm_sequencer
// Brief    : Self-checking bench for lmsm_sequencer against a list-based model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_lmsm_sequencer;
  localparam int         AW = 16;
  localparam int         DW = 16;
  localparam logic [3:0] LM = 4'd6;
  localparam logic [3:0] SM = 4'd7;
`ifdef LMSM_ADDR_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_mem_r, in_mem_w, in_rc_wv, flush;
  logic [3:0]    opcode_in;
  logic [7:0]    reg_mask;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] in_store, rs_data;
  logic [2:0]    in_rc_addr;
  logic          stall, busy, mem_r, mem_w, rc_w_valid, valid_out, addr_err;
  logic [2:0]    rs_addr, rc_addr;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] store_data;
  logic [3:0]    opcode_out;

  logic [DW-1:0] rf [8];
  assign rs_data = rf[rs_addr];

  always #5 clk = ~clk;

  lmsm_sequencer #(.AW(AW), .DW(DW), .LM_OP(LM), .SM_OP(SM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode_in(opcode_in), .reg_mask(reg_mask),
    .base_addr(base_addr), .in_mem_r(in_mem_r), .in_mem_w(in_mem_w), .in_store(in_store),
    .in_rc_addr(in_rc_addr), .in_rc_wv(in_rc_wv), .flush(flush), .rs_data(rs_data),
    .stall(stall), .busy(busy), .rs_addr(rs_addr), .mem_r(mem_r), .mem_w(mem_w),
    .ls_addr(ls_addr), .store_data(store_data), .opcode_out(opcode_out), .rc_addr(rc_addr),
    .rc_w_valid(rc_w_valid), .valid_out(valid_out), .addr_err(addr_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending instruction as an ascending list of register numbers.
  bit            m_busy = 0, m_lm = 0, m_err = 0;
  int            m_regs[$];
  int            m_idx = 0;
  logic [AW-1:0] m_base = '0;

  logic          e_stall, e_busy, e_valid, e_mr, e_mw, e_rcwv, e_err;
  logic [AW-1:0] e_ls;
  logic [DW-1:0] e_sd;
  logic [3:0]    e_op;
  logic [2:0]    e_rc, e_rs;
  bit            c_mem, c_ls, c_sd, c_op, c_rc, c_rs;

  logic [AW-1:0] la[$];
  int            lr[$];
  logic [DW-1:0] ld[$];
  int            n_stall = 0;
  logic          s_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op);
    return (op == LM) || (op == SM);
  endfunction

  task automatic compute_exp();
    int            k;
    logic [AW-1:0] a;
    bit            last, abort;
    {e_stall, e_busy, e_valid, e_mr, e_mw, e_rcwv} = '0;
    e_ls = '0; e_sd = '0; e_op = '0; e_rc = '0; e_rs = '0;
    e_err = m_err;
    c_mem = 1; c_ls = 0; c_sd = 0; c_op = 0; c_rc = 0; c_rs = 0;
    if (rst) begin
      e_err = 0;
      {c_ls, c_sd, c_op, c_rc, c_rs} = '1;
    end else if (!m_busy) begin
      if (in_valid && !is_multi(opcode_in)) begin
        e_valid = 1; e_mr = in_mem_r; e_mw = in_mem_w; e_rcwv = in_rc_wv;
        e_ls = base_addr; e_sd = in_store; e_op = opcode_in; e_rc = in_rc_addr;
        {c_ls, c_sd, c_op, c_rc} = '1;
      end else if (in_valid) begin
        e_stall = (reg_mask != 8'd0);
      end else begin
        c_mem = 0;
      end
    end else begin
      k     = m_regs[m_idx];
      a     = m_base + AW'(m_idx);
      last  = (m_idx == m_regs.size() - 1);
      abort = FEAT && !last && (a == {AW{1'b1}});
      e_busy = 1; e_valid = 1; e_stall = !last && !abort;
      e_op = m_lm ? LM : SM; e_ls = a; c_op = 1; c_ls = 1;
      if (m_lm) begin
        e_mr = 1; e_rcwv = 1; e_rc = 3'(k); c_rc = 1;
      end else begin
        e_mw = 1; e_rs = 3'(k); c_rs = 1; e_sd = rf[k]; c_sd = 1;
      end
    end
    if (flush && !rst) begin
      e_mr = 0; e_mw = 0; e_valid = 0; e_rcwv = 0; e_stall = 0;
    end
  endtask

  task automatic update_model();
    logic [AW-1:0] a;
    bit            last;
    if (rst) begin
      m_busy = 0; m_err = 0;
    end else if (flush) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (in_valid && is_multi(opcode_in) && reg_mask != 8'd0) begin
        m_regs.delete();
        for (int i = 0; i < 8; i++) if (reg_mask[i]) m_regs.push_back(i);
        m_busy = 1; m_idx = 0; m_base = base_addr; m_lm = (opcode_in == LM);
      end
    end else begin
      a    = m_base + AW'(m_idx);
      last = (m_idx == m_regs.size() - 1);
      if (last) m_busy = 0;
      else if (FEAT && a == {AW{1'b1}}) begin
        m_busy = 0; m_err = 1;
      end else m_idx++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compute_exp();
    chk("stall", stall, e_stall);
    chk("busy", busy, e_busy);
    chk("valid_out", valid_out, e_valid);
    chk("addr_err", addr_err, e_err);
    if (c_mem) begin
      chk("mem_r", mem_r, e_mr);
      chk("mem_w", mem_w, e_mw);
      chk("rc_w_valid", rc_w_valid, e_rcwv);
    end
    if (c_ls) chk("ls_addr", ls_addr, e_ls);
    if (c_sd) chk("store_data", store_data, e_sd);
    if (c_op) chk("opcode_out", opcode_out, e_op);
    if (c_rc) chk("rc_addr", rc_addr, e_rc);
    if (c_rs) chk("rs_addr", rs_addr, e_rs);
    if (!rst && valid_out === 1'b1 && (mem_r === 1'b1 || mem_w === 1'b1)) begin
      la.push_back(ls_addr);
      lr.push_back(mem_r ? int'(rc_addr) : int'(rs_addr));
      ld.push_back(store_data);
    end
    if (stall === 1'b1) n_stall++;
    s_busy = busy;
    @(posedge clk);
    update_model();
    #1;
  endtask

  // Presents one instruction and holds it while the model says upstream is stalled.
  task automatic run_instr(input logic [3:0] op, input logic [7:0] mask, input logic [AW-1:0] base,
                           input bit v, input int flush_at, input int rst_at, output int ncyc);
    in_valid = v; opcode_in = op; reg_mask = mask; base_addr = base;
    ncyc = 0;
    forever begin
      flush = (ncyc == flush_at);
      rst   = (ncyc == rst_at);
      cycle();
      ncyc++;
      if (!e_stall) break;
      if (ncyc > 20) begin
        checks++; errors++;
        $display("FAIL timeout: instruction still stalled after %0d cycles", ncyc);
        break;
      end
    end
    in_valid = 0; flush = 0; rst = 0;
  endtask

  task automatic clear_log();
    la.delete(); lr.delete(); ld.delete(); n_stall = 0;
  endtask

  initial begin
    int            nc;
    logic [AW-1:0] exp_a [4];
    int            exp_r [4];
    int            r, fa, ra;
    logic [3:0]    op;
    logic [7:0]    msk;
    logic [AW-1:0] bs;
    exp_a = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
    exp_r = '{0, 2, 5, 7};
    for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
    rst = 1; in_valid = 1; opcode_in = 4'd4; reg_mask = 8'h5A; base_addr = 16'h1357;
    in_mem_r = 1; in_mem_w = 1; in_store = 16'hCAFE; in_rc_addr = 3'd5; in_rc_wv = 1; flush = 0;

    // Reset: all outputs zero while rst is high.
    cycle(); cycle();
    chk("reset_busy", busy, 1'b0);
    chk("reset_valid", valid_out, 1'b0);
    rst = 0; in_valid = 0;
    cycle();

    // LM mask A5 at 0x40
    clear_log();
    run_instr(LM, 8'hA5, 16'h0040, 1, -1, -1, nc);
    chk("lm_cycles", nc, 5);
    chk("lm_stall_cycles", n_stall, 4);
    chk("lm_count", la.size(), 4);
    for (int i = 0; i < 4 && i < la.size(); i++) begin
      chk("lm_addr", la[i], exp_a[i]);
      chk("lm_reg", lr[i], exp_r[i]);
    end
    cycle();
    chk("lm_idle_after", s_busy, 1'b0);

    // SM single register
    clear_log();
    rf[0] = 16'hBEEF;
    run_instr(SM, 8'h01, 16'h1234, 1, -1, -1, nc);
    chk("sm1_stall_cycles", n_stall, 1);
    chk("sm1_count", la.size(), 1);
    if (la.size() > 0) begin
      chk("sm1_addr", la[0], 16'h1234);
      chk("sm1_data", ld[0], 16'hBEEF);
      chk("sm1_rs", lr[0], 0);
    end

    // LM with empty mask is a lone bubble
    clear_log();
    run_instr(LM, 8'h00, 16'h0100, 1, -1, -1, nc);
    chk("lm0_cycles", nc, 1);
    chk("lm0_count", la.size(), 0);
    chk("lm0_stall_cycles", n_stall, 0);

    // Pass-through load
    clear_log();
    in_mem_r = 1; in_mem_w = 0; in_store = 16'h5A5A; in_rc_addr = 3'd3; in_rc_wv = 1;
    run_instr(4'd4, 8'h00, 16'h0ABC, 1, -1, -1, nc);
    chk("pt_count", la.size(), 1);
    if (la.size() > 0) begin
      chk("pt_addr", la[0], 16'h0ABC);
      chk("pt_rc", lr[0], 3);
    end
    chk("pt_stall_cycles", n_stall, 0);

    // SM FF with flush in the third transfer cycle
    clear_log();
    run_instr(SM, 8'hFF, 16'h2000, 1, 3, -1, nc);
    chk("flush_writes", la.size(), 2);
    cycle();
    chk("flush_idle_after", s_busy, 1'b0);

    // LM 03 at top of memory
    clear_log();
    run_instr(LM, 8'h03, 16'hFFFF, 1, -1, -1, nc);
    cycle();
    chk("wrap_count", la.size(), FEAT ? 1 : 2);
    if (la.size() > 0) chk("wrap_addr0", la[0], 16'hFFFF);
    if (!FEAT && la.size() > 1) chk("wrap_addr1", la[1], 16'h0000);
    chk("wrap_err", addr_err, FEAT);

    // Reset mid-sequence stops further accesses
    clear_log();
    run_instr(LM, 8'hFF, 16'h0100, 1, -1, 2, nc);
    cycle();
    chk("rst_mid_count", la.size(), 1);
    chk("rst_mid_idle", s_busy, 1'b0);
    chk("rst_mid_err", addr_err, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      r   = int'($urandom_range(0, 9));
      op  = (r < 4) ? LM : (r < 8) ? SM : 4'($urandom_range(0, 15));
      msk = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bs  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
      fa  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
      ra  = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 8)) : -1;
      for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
      in_mem_r = 1'($urandom); in_mem_w = 1'($urandom); in_store = 16'($urandom);
      in_rc_addr = 3'($urandom); in_rc_wv = 1'($urandom);
      run_instr(op, msk, bs, $urandom_range(0, 9) != 0, fa, ra, nc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
